// File: rtl/lane_expander_pkg.sv
// Shared widths and mask-counting helpers for the lane expander datapath.
// The helpers are pure combinational functions; they carry no latency or flow control of their own.
package lane_expander_pkg;

    localparam int LANES     = 8;
    localparam int DEPTH     = 2 * LANES;
    localparam int MAX_LANES = 64;

    typedef logic [$clog2(LANES+1)-1:0] count_t;
    typedef logic [$clog2(DEPTH)-1:0]   ptr_t;
    typedef logic [$clog2(DEPTH+1)-1:0] occ_t;

    function automatic int popcount(input logic [MAX_LANES-1:0] m);
        int c;
        c = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (m[i]) c++;
        end
        return c;
    endfunction

    // Number of set bits strictly below bit position o.
    function automatic int prefix_pop(input logic [MAX_LANES-1:0] m, input int o);
        int c;
        c = 0;
        for (int i = 0; i < MAX_LANES; i++) begin
            if (i < o && m[i]) c++;
        end
        return c;
    endfunction

endpackage

// File: rtl/lane_scatter.sv
// Combinational scatter: the k-th packed element lands in the lane holding the k-th set mask bit.
// Zero latency, no flow control; unmasked lanes are driven to zero.
module lane_scatter
    import lane_expander_pkg::*;
#(
    parameter type T = logic [7:0],
    parameter int  N = LANES
) (
    input  logic [N*$bits(T)-1:0] win_dat,
    input  logic [N-1:0]          mask,
    output logic [N*$bits(T)-1:0] lane_dat
);

    localparam int W = $bits(T);

    always_comb begin
        lane_dat = '0;
        for (int o = 0; o < N; o++) begin
            if (mask[o]) begin
                lane_dat[o*W +: W] = win_dat[prefix_pop(MAX_LANES'(mask), o)*W +: W];
            end
        end
    end

endmodule

// File: rtl/lane_expander.sv
// Scatters FIFO-ordered packed elements into the lanes chosen by each mask command.
// Mask to output takes 2 cycles minimum; output holds under backpressure and stalls issue.
module lane_expander
    import lane_expander_pkg::*;
#(
    parameter type T = logic [7:0],
    parameter int  N = LANES,
    parameter int  D = 2 * N
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [$clog2(N+1)-1:0]   in_count,
    input  logic [N*$bits(T)-1:0]    in_data,
    input  logic                     mask_valid,
    output logic                     mask_ready,
    input  logic [N-1:0]             mask,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_mask,
    output logic [N*$bits(T)-1:0]    out_data
);

    localparam int W  = $bits(T);
    localparam int CW = $clog2(N+1);
    localparam int PW = $clog2(D);
    localparam int OW = $clog2(D+1);

    localparam logic [OW-1:0] OCC_IN_MAX = OW'(D - N);
    localparam logic [CW-1:0] N_CNT      = CW'(N);

    logic [W-1:0]    buf_q [D];
    logic [W-1:0]    buf_d [D];
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [OW-1:0]   occ_q, occ_d;

    logic            s1_vld_q, s1_vld_d;
    logic [N-1:0]    mask_q, mask_d;
    logic [CW-1:0]   pop_q, pop_d;

    logic            out_valid_q, out_valid_d;
    logic [N-1:0]    out_mask_q, out_mask_d;
    logic [N*W-1:0]  out_data_q, out_data_d;

    logic [N*W-1:0]  win_dat;
    logic [N*W-1:0]  lane_dat;
    logic            in_fire;
    logic            mask_fire;
    logic            issue;

    // Admission only looks at registered occupancy, so a full N-element beat always fits.
    assign in_ready   = (occ_q <= OCC_IN_MAX);
    assign issue      = s1_vld_q && (occ_q >= OW'(pop_q)) && (!out_valid_q || out_ready);
    assign mask_ready = !s1_vld_q || issue;
    assign in_fire    = in_valid && in_ready;
    assign mask_fire  = mask_valid && mask_ready;

    assign out_valid  = out_valid_q;
    assign out_mask   = out_mask_q;
    assign out_data   = out_data_q;

    always_comb begin
        for (int j = 0; j < N; j++) begin
            win_dat[j*W +: W] = buf_q[rd_ptr_q + PW'(j)];
        end
    end

    lane_scatter #(
        .T (T),
        .N (N)
    ) u_scatter (
        .win_dat  (win_dat),
        .mask     (mask_q),
        .lane_dat (lane_dat)
    );

    always_comb begin
        buf_d = buf_q;
        if (in_fire) begin
            for (int k = 0; k < N; k++) begin
                if (CW'(k) < in_count) begin
                    buf_d[wr_ptr_q + PW'(k)] = in_data[k*W +: W];
                end
            end
        end
    end

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        s1_vld_d    = s1_vld_q;
        mask_d      = mask_q;
        pop_d       = pop_q;
        out_valid_d = out_valid_q;
        out_mask_d  = out_mask_q;
        out_data_d  = out_data_q;

        if (in_fire) begin
            wr_ptr_d = wr_ptr_q + PW'(in_count);
        end

        // Elements written this cycle are not yet counted; they become eligible next cycle.
        occ_d = occ_q + (in_fire ? OW'(in_count) : '0) - (issue ? OW'(pop_q) : '0);

        if (issue) begin
            rd_ptr_d    = rd_ptr_q + PW'(pop_q);
            out_valid_d = 1'b1;
            out_mask_d  = mask_q;
            out_data_d  = lane_dat;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (mask_fire) begin
            s1_vld_d = 1'b1;
            mask_d   = mask;
            pop_d    = CW'(popcount(MAX_LANES'(mask)));
        end else if (issue) begin
            s1_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            occ_q       <= '0;
            s1_vld_q    <= 1'b0;
            mask_q      <= '0;
            pop_q       <= '0;
            out_valid_q <= 1'b0;
            out_mask_q  <= '0;
            out_data_q  <= '0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            occ_q       <= occ_d;
            s1_vld_q    <= s1_vld_d;
            mask_q      <= mask_d;
            pop_q       <= pop_d;
            out_valid_q <= out_valid_d;
            out_mask_q  <= out_mask_d;
            out_data_q  <= out_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && in_fire) begin
            assert (in_count <= N_CNT);
        end
    end

endmodule
